// File: rtl/double_ge_arbiter_if.sv
// Requester-side bundle of the two-port double_ge arbiter: request handshakes
// with their IEEE-754 double operands, plus the per-requester response pulses.
`timescale 1ns/1ps

interface double_ge_arbiter_if;
  logic        req0_valid;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        req1_ready;
  logic        rsp0_valid;
  logic        rsp0_z;
  logic        rsp1_valid;
  logic        rsp1_z;

  // Requester side.
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_z, rsp1_valid, rsp1_z
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_z, rsp1_valid, rsp1_z
  );
endinterface

// File: rtl/double_ge_arbiter.sv
// Two-requester round-robin front end for one shared, pipelined double a>=b
// comparator; a tag pipeline routes each result back to the requester that issued it.
`timescale 1ns/1ps

module double_ge_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  double_ge_arbiter_if.slave  bus,
  output logic [63:0]         cmp_a,
  output logic [63:0]         cmp_b,
  input  logic                cmp_z,
  output logic [15:0]         grant_count
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("double_ge_arbiter: LATENCY must be within 1..8");
  end

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic                   ptr_q,   ptr_d;
  tag_t [LATENCY-1:0]     tag_q,   tag_d;
  logic [15:0]            count_q, count_d;

  logic gnt;
  logic gnt_id;
  tag_t last_tag;
  logic rsp0_hit;
  logic rsp1_hit;

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    gnt            = 1'b0;
    gnt_id         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    cmp_a          = 64'h0;
    cmp_b          = 64'h0;
    ptr_d          = ptr_q;
    count_d        = count_q;
    tag_d          = '0;

    // Contention is settled by the pointer; a lone requester wins outright.
    // Holding ready low during reset keeps requesters from transferring into flops that cannot capture.
    gnt    = rst_n & (bus.req0_valid | bus.req1_valid);
    gnt_id = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;

    bus.req0_ready = gnt & ~gnt_id;
    bus.req1_ready = gnt &  gnt_id;

    if (gnt) begin
      cmp_a   = gnt_id ? bus.req1_a : bus.req0_a;
      cmp_b   = gnt_id ? bus.req1_b : bus.req0_b;
      ptr_d   = ~gnt_id;
      count_d = count_q + 16'd1;
    end

    tag_d[0] = '{valid: gnt, id: gnt_id};
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The last tag stage lines up with cmp_z for the grant LATENCY cycles back.
  always_comb begin
    last_tag       = tag_q[LATENCY-1];
    rsp0_hit       = last_tag.valid & ~last_tag.id;
    rsp1_hit       = last_tag.valid &  last_tag.id;
    bus.rsp0_valid = rsp0_hit;
    bus.rsp1_valid = rsp1_hit;
    bus.rsp0_z     = rsp0_hit & cmp_z;
    bus.rsp1_z     = rsp1_hit & cmp_z;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of the order in which the simulator evaluates processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag valids must clear on reset, otherwise grants issued
      // before reset would surface later as stray response pulses.
      ptr_q   <= 1'b0;
      tag_q   <= '0;
      count_q <= 16'h0;
    end else begin
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign grant_count = count_q;

endmodule

// File: tb/tb_double_ge_arbiter.sv
// Scoreboard bench: two arbiters (LATENCY 1 and 3) share one random stimulus stream,
// with a behavioural comparator and a round-robin reference model.
`timescale 1ns/1ps

module tb_double_ge_arbiter;

  localparam logic [63:0] D_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_TWO  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] D_NINF = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] D_NZ   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] D_NAN  = 64'h7FF8_0000_0000_0000;

  typedef struct {
    bit id;
    bit z;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        req0_valid = 1'b0;
  logic [63:0] req0_a     = 64'h0;
  logic [63:0] req0_b     = 64'h0;
  logic        req1_valid = 1'b0;
  logic [63:0] req1_a     = 64'h0;
  logic [63:0] req1_b     = 64'h0;

  logic [1:0]        l_rdy0, l_rdy1, l_rv0, l_rv1, l_rz0, l_rz1;
  logic [1:0][63:0]  l_cmpa, l_cmpb;
  logic [1:0][15:0]  l_gc;

  // Behavioural comparator: one result per cycle, delayed by a history line.
  logic [7:0] hist [2];
  logic       pend [2];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  bit          m_ptr = 1'b0;
  logic [15:0] m_gc  = 16'h0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : 3;
    double_ge_arbiter_if bus ();
    logic [63:0] cmp_a;
    logic [63:0] cmp_b;
    logic [15:0] gc;

    assign bus.req0_valid = req0_valid;
    assign bus.req0_a     = req0_a;
    assign bus.req0_b     = req0_b;
    assign bus.req1_valid = req1_valid;
    assign bus.req1_a     = req1_a;
    assign bus.req1_b     = req1_b;

    assign l_rdy0[g] = bus.req0_ready;
    assign l_rdy1[g] = bus.req1_ready;
    assign l_rv0[g]  = bus.rsp0_valid;
    assign l_rv1[g]  = bus.rsp1_valid;
    assign l_rz0[g]  = bus.rsp0_z;
    assign l_rz1[g]  = bus.rsp1_z;
    assign l_cmpa[g] = cmp_a;
    assign l_cmpb[g] = cmp_b;
    assign l_gc[g]   = gc;

    double_ge_arbiter #(.LATENCY(L)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_z       (hist[g][L-1]),
      .grant_count (gc)
    );
  end

  function automatic bit ge(logic [63:0] a, logic [63:0] b);
    return $bitstoreal(a) >= $bitstoreal(b);
  endfunction

  function automatic logic [63:0] rand_dbl();
    case ($urandom_range(0, 9))
      0:       return 64'h0;
      1:       return D_NZ;
      2:       return D_PINF;
      3:       return D_NINF;
      4:       return D_NAN;
      5:       return D_ONE;
      6:       return D_TWO;
      7:       return {$urandom, $urandom};
      default: return $realtobits(real'($urandom_range(0, 20)) - 10.0);
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) pend[g] = ge(l_cmpa[g], l_cmpb[g]);
  end

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) hist[g] = {hist[g][6:0], pend[g]};
  end

  // Monitor: pops the entry due this cycle and compares both response ports.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      exp_t h;
      bit   have;
      bit   e0;
      bit   e1;
      have = 1'b0;
      h    = '{id: 1'b0, z: 1'b0, due: 0};
      if (g == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin h = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin h = q1.pop_front(); have = 1'b1; end
      end
      e0 = have && !h.id;
      e1 = have &&  h.id;
      check($sformatf("lane%0d rsp0_valid", g), 64'(l_rv0[g]), 64'(e0));
      check($sformatf("lane%0d rsp1_valid", g), 64'(l_rv1[g]), 64'(e1));
      check($sformatf("lane%0d rsp0_z", g),     64'(l_rz0[g]), 64'(e0 && h.z));
      check($sformatf("lane%0d rsp1_z", g),     64'(l_rz1[g]), 64'(e1 && h.z));
    end
  end

  // Drive one cycle of requests, predict the grant, and check the combinational outputs.
  task automatic drive(bit v0, bit v1, logic [63:0] a0, logic [63:0] b0,
                       logic [63:0] a1, logic [63:0] b1);
    bit          gnt;
    bit          gid;
    logic [63:0] ea;
    logic [63:0] eb;
    exp_t        e;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    gnt = v0 || v1;
    gid = (v0 && v1) ? m_ptr : v1;
    ea  = gnt ? (gid ? a1 : a0) : 64'h0;
    eb  = gnt ? (gid ? b1 : b0) : 64'h0;
    if (gnt) begin
      e.id  = gid;
      e.z   = ge(ea, eb);
      e.due = cyc + 1;
      q0.push_back(e);
      e.due = cyc + 3;
      q1.push_back(e);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("lane%0d req0_ready", g), 64'(l_rdy0[g]), 64'(gnt && !gid));
      check($sformatf("lane%0d req1_ready", g), 64'(l_rdy1[g]), 64'(gnt &&  gid));
      check($sformatf("lane%0d cmp_a", g), l_cmpa[g], ea);
      check($sformatf("lane%0d cmp_b", g), l_cmpb[g], eb);
      check($sformatf("lane%0d grant_count", g), 64'(l_gc[g]), 64'(m_gc));
    end
    if (gnt) begin
      m_ptr = !gid;
      m_gc  = m_gc + 16'd1;
    end
  endtask

  task automatic apply(bit v0, bit v1, logic [63:0] a0, logic [63:0] b0,
                       logic [63:0] a1, logic [63:0] b1);
    @(posedge clk);
    #2;
    drive(v0, v1, a0, b0, a1, b1);
  endtask

  task automatic idle(int n);
    repeat (n) apply(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
  endtask

  // Reset with both requesters asserting, then release so the first edge grants.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    m_ptr = 1'b0;
    m_gc  = 16'h0;
    req0_valid = 1'b1; req0_a = D_TWO; req0_b = D_ONE;
    req1_valid = 1'b1; req1_a = D_ONE; req1_b = D_TWO;
    repeat (2) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("lane%0d reset req0_ready", g), 64'(l_rdy0[g]), 64'h0);
        check($sformatf("lane%0d reset req1_ready", g), 64'(l_rdy1[g]), 64'h0);
        check($sformatf("lane%0d reset grant_count", g), 64'(l_gc[g]), 64'h0);
        check($sformatf("lane%0d reset cmp_a", g), l_cmpa[g], 64'h0);
      end
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, D_TWO, D_ONE, D_ONE, D_TWO);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      hist[g] = 8'h0;
      pend[g] = 1'b0;
    end
    #1 rst_n = 1'b0;

    // Reset state, first grant right after release, then alternating contention.
    do_reset();
    repeat (3) apply(1'b1, 1'b1, D_TWO, D_ONE, D_ONE, D_TWO);
    idle(1);
    for (int g = 0; g < 2; g++) check($sformatf("lane%0d grant_count after 4", g), 64'(l_gc[g]), 64'd4);
    idle(3);

    // Single requesters with known results.
    apply(1'b1, 1'b0, D_TWO, D_ONE, 64'h0, 64'h0);
    idle(3);
    apply(1'b0, 1'b1, 64'h0, 64'h0, D_ONE, D_TWO);
    idle(4);

    // Pointer must survive an idle gap.
    apply(1'b1, 1'b1, D_ONE, D_ONE, D_TWO, D_TWO);
    idle(3);
    apply(1'b1, 1'b1, D_NZ, 64'h0, D_NAN, D_ONE);
    apply(1'b1, 1'b1, D_NINF, D_PINF, D_PINF, D_PINF);
    idle(4);

    // Randomized traffic, including sustained back-to-back contention.
    repeat (3000) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            rand_dbl(), rand_dbl(), rand_dbl(), rand_dbl());
    end
    idle(4);

    // Reset with two grants in flight on the deep lane.
    apply(1'b1, 1'b0, D_TWO, D_ONE, 64'h0, 64'h0);
    apply(1'b0, 1'b1, 64'h0, 64'h0, D_TWO, D_ONE);
    do_reset();
    idle(4);

    // Counter wrap: 65537 grants since reset (do_reset issues the first).
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      if (i[0]) apply(1'b1, 1'b0, rand_dbl(), rand_dbl(), 64'h0, 64'h0);
      else      apply(1'b0, 1'b1, 64'h0, 64'h0, rand_dbl(), rand_dbl());
    end
    idle(1);
    for (int g = 0; g < 2; g++) check($sformatf("lane%0d grant_count wrap", g), 64'(l_gc[g]), 64'd1);
    idle(4);

    check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/double_ge_arbiter.md
DOUBLE_GE_ARBITER -- requirements
Module: double_ge_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: cycles from operands presented on cmp_a/cmp_b to result valid on cmp_z; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has a compare pending.
REQ-005 req0_a, req0_b  input  64 each  requester 0 IEEE-754 double operands.
REQ-006 req0_ready  output  1  requester 0 granted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  as REQ-004..006 for requester 1.
REQ-008 rsp0_valid  output  1  one-cycle pulse, result for requester 0.
REQ-009 rsp0_z  output  1  a >= b result for requester 0; meaningful only while rsp0_valid=1.
REQ-010 rsp1_valid, rsp1_z  as REQ-008..009 for requester 1.
REQ-011 cmp_a, cmp_b  output  64 each  operands to the shared double_ge comparator.
REQ-012 cmp_z  input  1  comparator result, LATENCY cycles after operands.
REQ-013 grant_count  output  16  total grants since reset.

Function
REQ-014 At most one grant per cycle; a request transfers when reqN_valid=1 and reqN_ready=1 in the same cycle.
REQ-015 reqN_ready is combinational from reqN_valid and the priority pointer; no dependence on any ready->valid path.
REQ-016 Only one requester valid -> that requester granted, regardless of pointer.
REQ-017 Both valid -> the requester indicated by the priority pointer is granted; the other has ready=0.
REQ-018 Priority pointer: 1-bit register; after a grant to requester N it points to the other requester; with no grant it holds.
REQ-019 cmp_a/cmp_b = granted requester's operands in the grant cycle (combinational mux); 64'h0 on both when no grant.
REQ-020 Tag pipeline: LATENCY-stage shift register, each stage {valid, id}; stage 0 loads {grant, granted id} each cycle.
REQ-021 rspN_valid = last tag stage valid with id=N; rspN_z = cmp_z in that cycle, else 0.
REQ-022 Response for a grant in cycle T appears in cycle T+LATENCY exactly; responses in grant order; no backpressure on responses.
REQ-023 Back-to-back grants every cycle sustained; throughput 1 compare/cycle; no bubbles inserted.
REQ-024 rsp0_valid and rsp1_valid never both 1 in the same cycle.
REQ-025 grant_count increments by 1 per grant; wraps 16'hFFFF -> 16'h0000.
REQ-026 Operand values (NaN, +/-0, inf) are not interpreted; results are passed from cmp_z unchanged.

Reset
REQ-027 rst_n=0 asynchronously forces: pointer -> requester 0, all tag stages invalid, grant_count=0, rsp0_valid=rsp1_valid=0, rsp0_z=rsp1_z=0.
REQ-028 reqN_ready=0 while rst_n=0.
REQ-029 Reset mid-operation: in-flight tags discarded; no response pulse is emitted for any grant made before reset.
REQ-030 First grant possible in the first rising edge with rst_n=1.

Verification
REQ-031 LATENCY=1; req0 only, a=64'h4000000000000000 (2.0), b=64'h3FF0000000000000 (1.0) -> req0_ready=1 same cycle; rsp0_valid=1, rsp0_z=1 one cycle later; rsp1_valid stays 0.
REQ-032 Both valid continuously after reset for 4 cycles -> grants 0,1,0,1; responses alternate rsp0/rsp1 at LATENCY; grant_count=4.
REQ-033 LATENCY=3; req1 a=1.0, b=2.0 granted at cycle T -> rsp1_valid=1, rsp1_z=0 at T+3 only.
REQ-034 LATENCY=3; 2 grants in flight, rst_n pulsed low -> no rspN_valid after reset release; pointer = 0; grant_count=0.
REQ-035 65537 single-requester grants -> grant_count=1 (wrap).
REQ-036 Idle cycles -> cmp_a=cmp_b=0, both ready=0, pointer unchanged across the idle gap.
